in_service_ctrl: RTL and testbench
==================================

// Module: in_service_ctrl
// PURPOSE
//  Parametrised, clocked in-service register (ISR) controller for the PIC. Sets ISR bits on INTA
//  handshakes and clears them on AEOI or OCW2 EOI commands (non-specific/specific).
//  Tracks the rotating priority base, supporting rotate-on-EOI, rotate-in-AEOI and set-priority.
//  Sits between the priority resolver (drives CHOSEN) and the control logic (drives INTA/OCW2).
// PARAMETERS
//  N_CH        8               number of IR channels (2..16)
//  LVL_W       $clog2(N_CH)    width of a level index
//  INTA_PULSES 2               INTA strobes per acknowledge cycle (2 = 8086 mode, 3 = 8080 mode)
// PORTS
//  CLK           in   1      system clock, all state on rising edge
//  RST_N         in   1      asynchronous active-low reset
//  ICW_INIT      in   1      init strobe (ICW1 write): clears ISR, priority base, AEOI-rotate flag
//  INTA_STB      in   1      one-cycle strobe per INTA pulse, already synchronised to CLK
//  CHOSEN        in   N_CH   candidate request(s) from the priority resolver
//  AEOI          in   1      auto-EOI mode (from ICW4)
//  OCW2_VALID    in   1      one-cycle strobe: OCW2 written
//  OCW2_CMD      in   3      {R,SL,EOI}
//  OCW2_LEVEL    in   LVL_W  L2..L0 level for specific/set-priority commands
//  ISR           out  N_CH   in-service register
//  LOWEST_PRIO   out  LVL_W  lowest-priority level; level (LOWEST_PRIO+1) mod N_CH is highest
//  ACTIVE_LEVEL  out  LVL_W  highest-priority in-service level (0 when none)
//  ISR_ACTIVE    out  1      |ISR
//  SPURIOUS      out  1      one-cycle pulse: first INTA found CHOSEN==0
// BEHAVIOUR
//  Reset (RST_N=0, async): ISR=0, LOWEST_PRIO=N_CH-1, rot_aeoi=0, state IDLE, SPURIOUS=0.
//  ICW_INIT: same values, synchronous, and it overrides every other input in that cycle.
//  All outputs are registered; effects are visible the cycle after the causing strobe.
//  INTA FSM: IDLE -> ACK (pulse count cnt=1) -> ... -> IDLE when cnt reaches INTA_PULSES.
//   - First strobe in IDLE:
//     . pick the highest-priority bit of CHOSEN under the current rotation (multi-hot allowed).
//     . set that ISR bit and latch its level as ack_lvl.
//     . CHOSEN==0: no ISR change, SPURIOUS pulses, and the FSM still counts the pulses.
//   - Last strobe: if AEOI and not spurious, clear ISR[ack_lvl].
//     If rot_aeoi is also set, LOWEST_PRIO<=ack_lvl.
//   - Intermediate strobes only advance cnt. CHOSEN is ignored after the first strobe.
//  OCW2 (acted on when OCW2_VALID=1):
//   001 non-specific EOI:   clear the highest-priority set ISR bit; no-op if ISR==0.
//   011 specific EOI:       clear ISR[OCW2_LEVEL].
//   101 rotate on NS EOI:   as 001, plus LOWEST_PRIO<=cleared level; ISR==0 -> no rotation.
//   111 rotate on spec EOI: clear ISR[OCW2_LEVEL]; LOWEST_PRIO<=OCW2_LEVEL.
//   110 set priority:       LOWEST_PRIO<=OCW2_LEVEL; ISR unchanged.
//   100 / 000:              set / clear rot_aeoi.
//   010:                    no operation.
//   OCW2_LEVEL >= N_CH (N_CH not a power of 2): the command is ignored entirely.
//  Simultaneous events: ISR_next = (ISR & ~clr_mask) | set_mask, so a set wins on the same bit.
//   If both paths rotate in one cycle, the OCW2 rotation wins.
//  Priority search uses LOWEST_PRIO from the current cycle (before any update).
//  Rotation wraps modulo N_CH. Priority order: LOWEST_PRIO+1 (highest) ... LOWEST_PRIO (lowest).
// STRUCTURE
//  pic_pkg:
//   - OCW2 command localparams (OCW2_NS_EOI, OCW2_SP_EOI, OCW2_ROT_NS, OCW2_ROT_SP, OCW2_SET_PR,
//     OCW2_ROT_AEOI_SET, OCW2_ROT_AEOI_CLR, OCW2_NOP)
//   - INTA state encoding (ST_IDLE, ST_ACK)
//  Sub-module pic_prio_pick #(N_CH):
//   - combinational rotating highest-priority finder, inputs vec + LOWEST_PRIO
//   - outputs found flag and level
//   - instantiated twice: once on CHOSEN, once on ISR
//  Top level holds the FSM, pulse counter, ISR, LOWEST_PRIO and rot_aeoi registers.
// TESTING
//  1 Reset, then 2 INTA with CHOSEN=8'h24, AEOI=0:
//    ISR=8'h04 after strobe 1; unchanged after strobe 2; ACTIVE_LEVEL=2.
//  2 AEOI=1, rot_aeoi=1 (cmd 100), INTA x2 with CHOSEN=8'h08:
//    ISR bit3 set, then cleared after strobe 2; LOWEST_PRIO=3.
//  3 ISR=8'h0A, cmd 101 -> ISR=8'h08, LOWEST_PRIO=1.
//    Next cmd 001 -> ISR=8'h00; a further cmd 001 is a no-op.
//  4 cmd 110 L=5, INTA with CHOSEN=8'h41 -> bit6 set (highest after 5).
//    Then cmd 111 L=6 -> ISR bit6 cleared, LOWEST_PRIO=6.
//  5 INTA with CHOSEN=0 -> SPURIOUS pulses once, ISR unchanged, FSM back in IDLE after 2 strobes.
//  6 Same-cycle cmd 011 L=3 and INTA with CHOSEN=8'h08 -> ISR bit3 stays set.
//    RST_N low mid-ACK -> ISR=0 and FSM IDLE at once; INTA_PULSES=3 run returns to IDLE on strobe 3.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared encodings for the PIC in-service controller: OCW2 command codes and
// the INTA acknowledge state type.
package pic_pkg;

    // OCW2 {R,SL,EOI} command codes
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
    localparam logic [2:0] OCW2_SET_PR       = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP       = 3'b111;

    // INTA handshake progress
    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } inta_state_e;

endpackage

// File: rtl/in_service_ctrl_if.sv
// Bus between the PIC control logic / priority resolver (master) and the
// in-service controller (slave).
interface in_service_ctrl_if #(
    parameter int N_CH  = 8,
    parameter int LVL_W = $clog2(N_CH)
);

    logic             ICW_INIT;
    logic             INTA_STB;
    logic [N_CH-1:0]  CHOSEN;
    logic             AEOI;
    logic             OCW2_VALID;
    logic [2:0]       OCW2_CMD;
    logic [LVL_W-1:0] OCW2_LEVEL;
    logic [N_CH-1:0]  ISR;
    logic [LVL_W-1:0] LOWEST_PRIO;
    logic [LVL_W-1:0] ACTIVE_LEVEL;
    logic             ISR_ACTIVE;
    logic             SPURIOUS;

    modport master (
        output ICW_INIT, INTA_STB, CHOSEN, AEOI, OCW2_VALID, OCW2_CMD, OCW2_LEVEL,
        input  ISR, LOWEST_PRIO, ACTIVE_LEVEL, ISR_ACTIVE, SPURIOUS
    );

    modport slave (
        input  ICW_INIT, INTA_STB, CHOSEN, AEOI, OCW2_VALID, OCW2_CMD, OCW2_LEVEL,
        output ISR, LOWEST_PRIO, ACTIVE_LEVEL, ISR_ACTIVE, SPURIOUS
    );

endinterface

// File: rtl/pic_prio_pick.sv
// Rotating highest-priority finder: level lowest_prio+1 (mod N_CH) is the
// highest priority, lowest_prio itself the lowest.
module pic_prio_pick #(
    parameter int N_CH  = 8,
    parameter int LVL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  vec,
    input  logic [LVL_W-1:0] lowest_prio,
    output logic             found,
    output logic [LVL_W-1:0] level
);

    // Walk from lowest to highest priority so the last hit is the winner
    always_comb begin
        int unsigned     idx;
        logic [LVL_W-1:0] lvl;
        found = 1'b0;
        level = '0;
        idx   = 0;
        lvl   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = 32'(lowest_prio) + 32'(N_CH) - k;
            if (idx >= 32'(N_CH)) begin
                idx = idx - 32'(N_CH);
            end
            lvl = LVL_W'(idx);
            if (vec[lvl]) begin
                found = 1'b1;
                level = lvl;
            end
        end
    end

endmodule

// File: rtl/in_service_ctrl.sv
// In-service register controller: sets ISR bits on INTA handshakes, clears
// them on AEOI or OCW2 EOI commands and tracks the rotating priority base.
module in_service_ctrl
    import pic_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int LVL_W       = $clog2(N_CH),
    parameter int INTA_PULSES = 2
) (
    input logic              CLK,
    input logic              RST_N,
    in_service_ctrl_if.slave bus
);

    localparam int               CNT_W   = $clog2(INTA_PULSES + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_CH - 1);

    inta_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] ack_lvl_q, ack_lvl_d;
    logic             spur_q, spur_d;
    logic [N_CH-1:0]  isr_q, isr_d;
    logic [LVL_W-1:0] lowest_q, lowest_d;
    logic             rot_aeoi_q, rot_aeoi_d;
    logic             spurious_q, spurious_d;

    logic [N_CH-1:0]  set_mask, clr_mask;
    logic             chosen_found, isr_found;
    logic [LVL_W-1:0] chosen_lvl, isr_lvl;
    logic             level_ok;

    pic_prio_pick #(.N_CH(N_CH), .LVL_W(LVL_W)) u_pick_chosen (
        .vec         (bus.CHOSEN),
        .lowest_prio (lowest_q),
        .found       (chosen_found),
        .level       (chosen_lvl)
    );

    pic_prio_pick #(.N_CH(N_CH), .LVL_W(LVL_W)) u_pick_isr (
        .vec         (isr_q),
        .lowest_prio (lowest_q),
        .found       (isr_found),
        .level       (isr_lvl)
    );

    assign level_ok = int'(bus.OCW2_LEVEL) < N_CH;

    // Next-state for the INTA FSM, ISR masks, priority base and AEOI-rotate flag.
    // The OCW2 block runs after the INTA block so its rotation wins a tie.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_lvl_d  = ack_lvl_q;
        spur_d     = spur_q;
        lowest_d   = lowest_q;
        rot_aeoi_d = rot_aeoi_q;
        spurious_d = 1'b0;
        set_mask   = '0;
        clr_mask   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.INTA_STB) begin
                    state_d = ST_ACK;
                    cnt_d   = CNT_W'(1);
                    if (chosen_found) begin
                        set_mask[chosen_lvl] = 1'b1;
                        ack_lvl_d            = chosen_lvl;
                        spur_d               = 1'b0;
                    end else begin
                        spur_d     = 1'b1;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (bus.INTA_STB) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(INTA_PULSES)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (bus.AEOI && !spur_q) begin
                            clr_mask[ack_lvl_q] = 1'b1;
                            if (rot_aeoi_q) begin
                                lowest_d = ack_lvl_q;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.OCW2_VALID && level_ok) begin
            case (bus.OCW2_CMD)
                OCW2_NS_EOI: begin
                    if (isr_found) clr_mask[isr_lvl] = 1'b1;
                end
                OCW2_SP_EOI: clr_mask[bus.OCW2_LEVEL] = 1'b1;
                OCW2_ROT_NS: begin
                    if (isr_found) begin
                        clr_mask[isr_lvl] = 1'b1;
                        lowest_d          = isr_lvl;
                    end
                end
                OCW2_ROT_SP: begin
                    clr_mask[bus.OCW2_LEVEL] = 1'b1;
                    lowest_d                 = bus.OCW2_LEVEL;
                end
                OCW2_SET_PR:       lowest_d   = bus.OCW2_LEVEL;
                OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
                OCW2_NOP:          ;
                default:           ;
            endcase
        end

        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    // State registers; ICW_INIT acts as a synchronous reset that beats everything
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_lvl_q  <= '0;
            spur_q     <= 1'b0;
            isr_q      <= '0;
            lowest_q   <= LVL_MAX;
            rot_aeoi_q <= 1'b0;
            spurious_q <= 1'b0;
        end else if (bus.ICW_INIT) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_lvl_q  <= '0;
            spur_q     <= 1'b0;
            isr_q      <= '0;
            lowest_q   <= LVL_MAX;
            rot_aeoi_q <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_lvl_q  <= ack_lvl_d;
            spur_q     <= spur_d;
            isr_q      <= isr_d;
            lowest_q   <= lowest_d;
            rot_aeoi_q <= rot_aeoi_d;
            spurious_q <= spurious_d;
        end
    end

    assign bus.ISR          = isr_q;
    assign bus.LOWEST_PRIO  = lowest_q;
    assign bus.ACTIVE_LEVEL = isr_found ? isr_lvl : '0;
    assign bus.ISR_ACTIVE   = |isr_q;
    assign bus.SPURIOUS     = spurious_q;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Bench for in_service_ctrl: an 8-channel 8086-mode instance checked every
// cycle against a behavioural model, plus a 6-channel 8080-mode instance
// checked with hand-computed values.
module tb_in_service_ctrl;

    logic CLK;
    logic RST_N;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 0;

    in_service_ctrl_if #(.N_CH(8), .LVL_W(3)) m ();
    in_service_ctrl_if #(.N_CH(6), .LVL_W(3)) b ();

    in_service_ctrl #(.N_CH(8), .LVL_W(3), .INTA_PULSES(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (m.slave)
    );

    in_service_ctrl #(.N_CH(6), .LVL_W(3), .INTA_PULSES(3)) dut3 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 8-channel instance ----------------
    bit [7:0] m_isr;
    int       m_low;
    bit       m_rot;
    bit       m_in_ack;
    int       m_cnt;
    int       m_ack;
    bit       m_spur_ack;
    bit       m_spur_out;

    // Highest-priority set level of v when 'low' is the lowest level; -1 if none
    function automatic int pick8(input logic [7:0] v, input int low);
        for (int k = 1; k <= 8; k++) begin
            int l;
            l = (low + k) % 8;
            if (((v >> l) & 8'd1) != 8'd0) return l;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_isr = '0; m_low = 7; m_rot = 0; m_in_ack = 0;
        m_cnt = 0; m_ack = 0; m_spur_ack = 0; m_spur_out = 0;
    endtask

    task automatic model_step();
        bit [7:0] set_b, clr_b;
        int p, lv, new_low;
        if (m.ICW_INIT) begin
            model_reset();
            return;
        end
        set_b = '0; clr_b = '0; new_low = m_low; m_spur_out = 0;
        if (m.INTA_STB) begin
            if (!m_in_ack) begin
                m_in_ack = 1;
                m_cnt = 1;
                p = pick8(m.CHOSEN, m_low);
                if (p < 0) begin
                    m_spur_ack = 1;
                    m_spur_out = 1;
                end else begin
                    m_spur_ack = 0;
                    m_ack = p;
                    set_b = 8'b1 << p;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 2) begin
                    m_in_ack = 0;
                    if (m.AEOI && !m_spur_ack) begin
                        clr_b = 8'b1 << m_ack;
                        if (m_rot) new_low = m_ack;
                    end
                end
            end
        end
        if (m.OCW2_VALID) begin
            lv = int'(m.OCW2_LEVEL);
            p  = pick8(m_isr, m_low);
            case (m.OCW2_CMD)
                3'b001: if (p >= 0) clr_b = clr_b | (8'b1 << p);
                3'b011: clr_b = clr_b | (8'b1 << lv);
                3'b101: if (p >= 0) begin clr_b = clr_b | (8'b1 << p); new_low = p; end
                3'b111: begin clr_b = clr_b | (8'b1 << lv); new_low = lv; end
                3'b110: new_low = lv;
                3'b100: m_rot = 1;
                3'b000: m_rot = 0;
                default: ;
            endcase
        end
        m_isr = (m_isr & ~clr_b) | set_b;
        m_low = new_low;
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_reset();
        else        model_step();
    end

    // Every-cycle comparison of the 8-channel instance against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            int p;
            p = pick8(m_isr, m_low);
            check("isr",          32'(m.ISR),          32'(m_isr));
            check("lowest_prio",  32'(m.LOWEST_PRIO),  32'(m_low));
            check("active_level", 32'(m.ACTIVE_LEVEL), (p < 0) ? 32'd0 : 32'(p));
            check("isr_active",   32'(m.ISR_ACTIVE),   32'(m_isr != 8'd0));
            check("spurious",     32'(m.SPURIOUS),     32'(m_spur_out));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_m(input bit inta, input logic [7:0] ch, input bit ov,
                         input logic [2:0] cmd, input logic [2:0] lv);
        m.INTA_STB = inta; m.CHOSEN = ch;
        m.OCW2_VALID = ov; m.OCW2_CMD = cmd; m.OCW2_LEVEL = lv;
        @(negedge CLK);
        m.INTA_STB = 1'b0; m.OCW2_VALID = 1'b0; m.ICW_INIT = 1'b0;
    endtask

    task automatic cyc_b(input bit inta, input logic [5:0] ch, input bit ov,
                         input logic [2:0] cmd, input logic [2:0] lv);
        b.INTA_STB = inta; b.CHOSEN = ch;
        b.OCW2_VALID = ov; b.OCW2_CMD = cmd; b.OCW2_LEVEL = lv;
        @(negedge CLK);
        b.INTA_STB = 1'b0; b.OCW2_VALID = 1'b0; b.ICW_INIT = 1'b0;
    endtask

    initial begin
        logic [7:0] ch;
        RST_N = 1'b0;
        m.ICW_INIT = 0; m.INTA_STB = 0; m.CHOSEN = '0; m.AEOI = 0;
        m.OCW2_VALID = 0; m.OCW2_CMD = '0; m.OCW2_LEVEL = '0;
        b.ICW_INIT = 0; b.INTA_STB = 0; b.CHOSEN = '0; b.AEOI = 0;
        b.OCW2_VALID = 0; b.OCW2_CMD = '0; b.OCW2_LEVEL = '0;
        @(negedge CLK);
        chk_en = 1;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // reset state
        check("rst_isr",    32'(m.ISR), 32'h00);
        check("rst_lowest", 32'(m.LOWEST_PRIO), 32'd7);
        check("rst_spur",   32'(m.SPURIOUS), 32'd0);

        // 1: plain acknowledge, multi-hot CHOSEN
        cyc_m(1, 8'h24, 0, 3'b000, 3'd0);
        check("t1_isr_s1", 32'(m.ISR), 32'h04);
        check("t1_active", 32'(m.ACTIVE_LEVEL), 32'd2);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        check("t1_isr_s2", 32'(m.ISR), 32'h04);

        // 2: auto-EOI with rotation
        cyc_m(0, 8'h00, 1, 3'b100, 3'd0);
        m.AEOI = 1;
        cyc_m(1, 8'h08, 0, 3'b000, 3'd0);
        check("t2_isr_s1", 32'(m.ISR), 32'h0C);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        check("t2_isr_s2", 32'(m.ISR), 32'h04);
        check("t2_lowest", 32'(m.LOWEST_PRIO), 32'd3);
        m.AEOI = 0;
        cyc_m(0, 8'h00, 1, 3'b000, 3'd0);
        cyc_m(0, 8'h00, 1, 3'b011, 3'd2);
        check("t2_clean", 32'(m.ISR), 32'h00);

        // 3: rotate on non-specific EOI, then non-specific EOIs
        cyc_m(1, 8'h02, 0, 3'b000, 3'd0);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        cyc_m(1, 8'h08, 0, 3'b000, 3'd0);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        check("t3_isr_0a", 32'(m.ISR), 32'h0A);
        cyc_m(0, 8'h00, 1, 3'b101, 3'd0);
        check("t3_isr_rot",    32'(m.ISR), 32'h08);
        check("t3_lowest_rot", 32'(m.LOWEST_PRIO), 32'd1);
        cyc_m(0, 8'h00, 1, 3'b001, 3'd0);
        check("t3_isr_ns", 32'(m.ISR), 32'h00);
        cyc_m(0, 8'h00, 1, 3'b001, 3'd0);
        check("t3_isr_noop",    32'(m.ISR), 32'h00);
        check("t3_lowest_noop", 32'(m.LOWEST_PRIO), 32'd1);

        // 4: set priority, then rotate on specific EOI
        cyc_m(0, 8'h00, 1, 3'b110, 3'd5);
        check("t4_lowest_set", 32'(m.LOWEST_PRIO), 32'd5);
        cyc_m(1, 8'h41, 0, 3'b000, 3'd0);
        check("t4_isr_bit6", 32'(m.ISR), 32'h40);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        cyc_m(0, 8'h00, 1, 3'b111, 3'd6);
        check("t4_isr_clr",    32'(m.ISR), 32'h00);
        check("t4_lowest_rot", 32'(m.LOWEST_PRIO), 32'd6);

        // 5: spurious acknowledge
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        check("t5_spur_hi", 32'(m.SPURIOUS), 32'd1);
        check("t5_isr",     32'(m.ISR), 32'h00);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        check("t5_spur_lo", 32'(m.SPURIOUS), 32'd0);
        cyc_m(1, 8'h01, 0, 3'b000, 3'd0);
        check("t5_idle_again", 32'(m.ISR), 32'h01);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        cyc_m(0, 8'h00, 1, 3'b011, 3'd0);

        // 6: set beats clear on the same bit; async reset mid-ACK
        cyc_m(1, 8'h08, 1, 3'b011, 3'd3);
        check("t6_set_wins", 32'(m.ISR), 32'h08);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);
        cyc_m(1, 8'h08, 0, 3'b000, 3'd0);
        #2 RST_N = 1'b0;
        #1;
        check("t6_async_isr",    32'(m.ISR), 32'h00);
        check("t6_async_lowest", 32'(m.LOWEST_PRIO), 32'd7);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc_m(1, 8'h10, 0, 3'b000, 3'd0);
        check("t6_idle_after_rst", 32'(m.ISR), 32'h10);
        cyc_m(1, 8'h00, 0, 3'b000, 3'd0);

        // ICW_INIT overrides a simultaneous acknowledge
        cyc_m(0, 8'h00, 1, 3'b110, 3'd3);
        m.ICW_INIT = 1;
        cyc_m(1, 8'hFF, 0, 3'b000, 3'd0);
        check("icw_isr",    32'(m.ISR), 32'h00);
        check("icw_lowest", 32'(m.LOWEST_PRIO), 32'd7);

        // 6-channel, three-pulse instance
        check("b_rst_lowest", 32'(b.LOWEST_PRIO), 32'd5);
        b.AEOI = 1;
        cyc_b(1, 6'h04, 0, 3'b000, 3'd0);
        check("b_s1", 32'(b.ISR), 32'h04);
        cyc_b(1, 6'h00, 0, 3'b000, 3'd0);
        check("b_s2", 32'(b.ISR), 32'h04);
        cyc_b(1, 6'h00, 0, 3'b000, 3'd0);
        check("b_s3_aeoi", 32'(b.ISR), 32'h00);
        cyc_b(1, 6'h01, 0, 3'b000, 3'd0);
        check("b_idle_again", 32'(b.ISR), 32'h01);
        cyc_b(0, 6'h00, 1, 3'b110, 3'd6);
        check("b_bad_setpr", 32'(b.LOWEST_PRIO), 32'd5);
        cyc_b(0, 6'h00, 1, 3'b001, 3'd7);
        check("b_bad_nseoi", 32'(b.ISR), 32'h01);
        cyc_b(1, 6'h00, 0, 3'b000, 3'd0);
        cyc_b(1, 6'h00, 0, 3'b000, 3'd0);
        check("b_aeoi_clr", 32'(b.ISR), 32'h00);
        cyc_b(0, 6'h00, 1, 3'b110, 3'd2);
        check("b_good_setpr", 32'(b.LOWEST_PRIO), 32'd2);

        // randomized traffic on the 8-channel instance
        for (int i = 0; i < 3000; i++) begin
            m.ICW_INIT = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) m.AEOI = ~m.AEOI;
            case ($urandom_range(0, 3))
                0:       ch = 8'h00;
                1:       ch = 8'b1 << $urandom_range(0, 7);
                default: ch = 8'($urandom);
            endcase
            cyc_m(($urandom_range(0, 2) == 0), ch, ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
